cpu_vpu_top: RTL and testbench

- Top-level clipping pipeline front end driving the rasterizer's stage-1 (f1) inputs.
- A frame timer in the clipper raises a frame tick about 60 times per second at 100 MHz.
- On each tick the clipper walks a fixed scene line list, clips every line to the 640x480 screen window, and presents each surviving segment on the f1 outputs with a one-cycle valid strobe.

---
 rtl/vpu_pkg.sv | 68 ++++++
 rtl/refresh_timer.sv | 19 +
 rtl/vpu_clipper.sv | 208 ++++++++++++++++++++
 rtl/cpu_vpu_top.sv | 31 +++
 tb/tb_cpu_vpu_top.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vpu_pkg.sv
// Shared types, screen limits, scene table and clip helpers for the VPU clipping front end.
// No clocked logic: latency and backpressure belong to the modules that use these definitions.
package vpu_pkg;
  localparam int REFRESH_MAX = 1666667;
  localparam int NUM_LINES   = 4;
  localparam int SCR_W       = 640;
  localparam int SCR_H       = 480;
  localparam int IDX_W       = $clog2(NUM_LINES);

  localparam logic signed [15:0] X_MAX = 16'(SCR_W - 1);
  localparam logic signed [15:0] Y_MAX = 16'(SCR_H - 1);

  localparam logic [3:0] OC_LEFT   = 4'b0001;
  localparam logic [3:0] OC_RIGHT  = 4'b0010;
  localparam logic [3:0] OC_BOTTOM = 4'b0100;
  localparam logic [3:0] OC_TOP    = 4'b1000;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } point_t;

  typedef struct packed {
    point_t p0;
    point_t p1;
  } line_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, CLASSIFY, SEARCH, BISECT0, BISECT1, EMIT, NEXT
  } clip_state_t;

  localparam line_t SCENE [NUM_LINES] = '{
    '{p0: '{x:  16'sd10,  y:  16'sd20},  p1: '{x: 16'sd100, y: 16'sd200}},
    '{p0: '{x: -16'sd100, y: -16'sd100}, p1: '{x: -16'sd10, y: -16'sd50}},
    '{p0: '{x: -16'sd100, y:  16'sd240}, p1: '{x: 16'sd700, y: 16'sd240}},
    '{p0: '{x:  16'sd320, y: -16'sd50},  p1: '{x: 16'sd320, y: 16'sd500}}
  };

  function automatic logic [3:0] outcode(input point_t p);
    logic [3:0] oc;
    oc = 4'd0;
    if ($signed(p.x) < 16'sd0)   oc = oc | OC_LEFT;
    if ($signed(p.x) > X_MAX)    oc = oc | OC_RIGHT;
    if ($signed(p.y) < 16'sd0)   oc = oc | OC_BOTTOM;
    if ($signed(p.y) > Y_MAX)    oc = oc | OC_TOP;
    return oc;
  endfunction

  // Sum in 17 bits so opposite-extreme coordinates cannot wrap before the halving.
  function automatic point_t midpoint(input point_t a, input point_t b);
    logic signed [16:0] sx;
    logic signed [16:0] sy;
    point_t m;
    sx = ($signed({a.x[15], a.x}) + $signed({b.x[15], b.x})) >>> 1;
    sy = ($signed({a.y[15], a.y}) + $signed({b.y[15], b.y})) >>> 1;
    m.x = sx[15:0];
    m.y = sy[15:0];
    return m;
  endfunction

  function automatic logic near(input point_t a, input point_t b);
    logic signed [16:0] dx;
    logic signed [16:0] dy;
    dx = $signed({a.x[15], a.x}) - $signed({b.x[15], b.x});
    dy = $signed({a.y[15], a.y}) - $signed({b.y[15], b.y});
    return (dx >= -17'sd1) && (dx <= 17'sd1) && (dy >= -17'sd1) && (dy <= 17'sd1);
  endfunction
endpackage

// File: rtl/refresh_timer.sv
// Frame timer: counts to REFRESH_MAX and raises frame_start combinationally at terminal count.
// Latency: tick in the terminal-count cycle; no backpressure, a tick nobody takes is simply lost.
module refresh_timer
  import vpu_pkg::*;
(
  input  logic clkin,
  input  logic rst_n,
  output logic frame_start
);
  logic [20:0] refresh_cnt;

  assign frame_start = (refresh_cnt == 21'(REFRESH_MAX));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)           refresh_cnt <= 21'd0;
    else if (frame_start) refresh_cnt <= 21'd0;
    else                  refresh_cnt <= refresh_cnt + 21'd1;
  end
endmodule

// File: rtl/vpu_clipper.sv
// Walks the scene table each frame tick, clips lines to the screen by outcode bisection (CLIP_STATS_EN adds reject_cnt).
// Latency: at most 40 cycles per line; no backpressure, ticks arriving while busy are dropped.
module vpu_clipper
  import vpu_pkg::*;
(
  input  logic               clkin,
  input  logic               rst_n,
  output logic signed [15:0] x0_in_f1,
  output logic signed [15:0] y0_in_f1,
  output logic signed [15:0] x1_in_f1,
  output logic signed [15:0] y1_in_f1,
  output logic               line_vld_f1,
  output logic               clip_busy
`ifdef CLIP_STATS_EN
  ,
  output logic [15:0]        reject_cnt
`endif
);
  logic frame_start;

  refresh_timer timing (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .frame_start (frame_start)
  );

  clip_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       srch_q, srch_d;
  point_t           p0_q, p0_d, p1_q, p1_d, s0_q, s0_d, s1_q, s1_d;
  point_t           ins_q, ins_d, bi_q, bi_d, bo_q, bo_d;
  point_t           c0_q, c0_d, c1_q, c1_d, out0_q, out0_d, out1_q, out1_d;
  logic             vld_q, vld_d, reject;
  point_t           mid_s, mid_b;
  logic [3:0]       oc0, oc1, oc_ms;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    srch_d  = srch_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    ins_d   = ins_q;
    bi_d    = bi_q;
    bo_d    = bo_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    vld_d   = 1'b0;
    reject  = 1'b0;
    mid_s   = midpoint(s0_q, s1_q);
    mid_b   = midpoint(bi_q, bo_q);
    oc0     = outcode(p0_q);
    oc1     = outcode(p1_q);
    oc_ms   = outcode(mid_s);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        p0_d    = SCENE[idx_q].p0;
        p1_d    = SCENE[idx_q].p1;
        state_d = CLASSIFY;
      end
      CLASSIFY: begin
        s0_d   = p0_q;
        s1_d   = p1_q;
        srch_d = '0;
        c0_d   = p0_q;
        c1_d   = p1_q;
        // An inside endpoint bisects against itself and converges at once, so it passes through unchanged.
        ins_d  = (oc0 == 4'd0) ? p0_q : p1_q;
        bi_d   = ins_d;
        bo_d   = p0_q;
        if ((oc0 | oc1) == 4'd0) begin
          state_d = EMIT;
        end else if ((oc0 & oc1) != 4'd0) begin
          reject  = 1'b1;
          state_d = NEXT;
        end else if (oc0 != 4'd0 && oc1 != 4'd0) begin
          state_d = SEARCH;
        end else begin
          state_d = BISECT0;
        end
      end
      SEARCH: begin
        srch_d = srch_q + 4'd1;
        if (oc_ms == 4'd0) begin
          ins_d   = mid_s;
          bi_d    = mid_s;
          bo_d    = p0_q;
          state_d = BISECT0;
        end else if (srch_q == 4'd15) begin
          reject  = 1'b1;
          state_d = NEXT;
        end else if ((oc_ms & outcode(s0_q)) != 4'd0) begin
          s0_d = mid_s;
        end else if ((oc_ms & outcode(s1_q)) != 4'd0) begin
          s1_d = mid_s;
        end else begin
          reject  = 1'b1;
          state_d = NEXT;
        end
      end
      BISECT0: begin
        if (near(bi_q, bo_q)) begin
          c0_d    = bi_q;
          bi_d    = ins_q;
          bo_d    = p1_q;
          state_d = BISECT1;
        end else if (outcode(mid_b) == 4'd0) begin
          bi_d = mid_b;
        end else begin
          bo_d = mid_b;
        end
      end
      BISECT1: begin
        if (near(bi_q, bo_q)) begin
          c1_d    = bi_q;
          state_d = EMIT;
        end else if (outcode(mid_b) == 4'd0) begin
          bi_d = mid_b;
        end else begin
          bo_d = mid_b;
        end
      end
      EMIT: begin
        out0_d  = c0_q;
        out1_d  = c1_q;
        vld_d   = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == IDX_W'(NUM_LINES - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      srch_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      ins_q   <= '0;
      bi_q    <= '0;
      bo_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      srch_q  <= srch_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      ins_q   <= ins_d;
      bi_q    <= bi_d;
      bo_q    <= bo_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      vld_q   <= vld_d;
    end
  end

  assign x0_in_f1    = out0_q.x;
  assign y0_in_f1    = out0_q.y;
  assign x1_in_f1    = out1_q.x;
  assign y1_in_f1    = out1_q.y;
  assign line_vld_f1 = vld_q;
  assign clip_busy   = (state_q != IDLE);

`ifdef CLIP_STATS_EN
  logic [15:0] rej_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                          rej_q <= 16'd0;
    else if (reject && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
  end

  assign reject_cnt = rej_q;
`else
  logic stats_unused;
  assign stats_unused = reject;
`endif
endmodule

// File: rtl/cpu_vpu_top.sv
// Clipping front end feeding rasterizer stage-1 inputs; CLIP_STATS_EN exposes reject_cnt.
// Latency: at most 40 cycles per scene line; no backpressure, one-cycle line_vld_f1 strobes.
module cpu_vpu_top (
  input  logic               clkin,
  input  logic               rst_n,
  output logic signed [15:0] x0_in_f1,
  output logic signed [15:0] y0_in_f1,
  output logic signed [15:0] x1_in_f1,
  output logic signed [15:0] y1_in_f1,
  output logic               line_vld_f1,
  output logic               clip_busy
`ifdef CLIP_STATS_EN
  ,
  output logic [15:0]        reject_cnt
`endif
);
  vpu_clipper clipper (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .x0_in_f1    (x0_in_f1),
    .y0_in_f1    (y0_in_f1),
    .x1_in_f1    (x1_in_f1),
    .y1_in_f1    (y1_in_f1),
    .line_vld_f1 (line_vld_f1),
    .clip_busy   (clip_busy)
`ifdef CLIP_STATS_EN
    ,
    .reject_cnt  (reject_cnt)
`endif
  );
endmodule

// File: tb/tb_cpu_vpu_top.sv
// Bench for cpu_vpu_top: scene-table vectors, frame triggers with random retrigger and mid-frame reset timing.
module tb_cpu_vpu_top;
  import vpu_pkg::*;

  typedef struct {
    int ax0, ay0, ax1, ay1;
    int ex0, ey0, ex1, ey1;
  } vec_t;

  typedef struct {
    int x0, y0, x1, y1;
  } seg_t;

  logic               clkin = 1'b0;
  logic               rst_n;
  logic signed [15:0] x0, y0, x1, y1;
  logic               vld, busy;
`ifdef CLIP_STATS_EN
  logic [15:0]        rej;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[4];
  seg_t exp_q[$];

  always #5 clkin = ~clkin;

  cpu_vpu_top dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .x0_in_f1    (x0),
    .y0_in_f1    (y0),
    .x1_in_f1    (x1),
    .y1_in_f1    (y1),
    .line_vld_f1 (vld),
    .clip_busy   (busy)
`ifdef CLIP_STATS_EN
    ,
    .reject_cnt  (rej)
`endif
  );

  function automatic int ref_oc(input int x, input int y);
    int oc;
    oc = 0;
    if (x < 0)          oc += 1;
    if (x > SCR_W - 1)  oc += 2;
    if (y < 0)          oc += 4;
    if (y > SCR_H - 1)  oc += 8;
    return oc;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic quiet(input int ncyc, output int bad);
    bad = 0;
    repeat (ncyc) begin
      @(negedge clkin);
      if (vld || busy) bad++;
    end
  endtask

  task automatic trigger();
    @(negedge clkin);
    chk("busy_before_trigger", busy, 0);
    force dut.clipper.timing.refresh_cnt = 21'd1666667;
    @(negedge clkin);
    release dut.clipper.timing.refresh_cnt;
    chk("busy_rise", busy, 1);
  endtask

  task automatic run_frame(input int retrig_at);
    int   n;
    int   cyc;
    bit   done;
    seg_t e;
    n = 0;
    cyc = 0;
    done = 0;
    while (!done) begin
      if (vld) begin
        if (n < exp_q.size()) begin
          e = exp_q[n];
          chk($sformatf("seg%0d_x0", n), x0, e.x0);
          chk($sformatf("seg%0d_y0", n), y0, e.y0);
          chk($sformatf("seg%0d_x1", n), x1, e.x1);
          chk($sformatf("seg%0d_y1", n), y1, e.y1);
        end
        n++;
      end
      if (!busy) begin
        done = 1;
      end else if (cyc >= 400) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: clip_busy still %0d after %0d cycles, required 0", busy, cyc);
        done = 1;
      end else begin
        @(negedge clkin);
        cyc++;
        if (cyc == retrig_at) force dut.clipper.timing.refresh_cnt = 21'd1666667;
        if (cyc == retrig_at + 1) release dut.clipper.timing.refresh_cnt;
      end
    end
    chk("strobe_count", n, exp_q.size());
    chk("frame_within_4x40_cycles", (cyc <= 4 * 40) ? 1 : 0, 1);
  endtask

  initial begin
    int   bad;
    int   r;
    int   k;
    int   edge_x[6];
    int   edge_y[6];
    seg_t last;

    vecs[0] = '{10, 20, 100, 200,      10, 20, 100, 200};
    vecs[1] = '{-100, -100, -10, -50,  0, 0, 0, 0};
    vecs[2] = '{-100, 240, 700, 240,   0, 240, 639, 240};
    vecs[3] = '{320, -50, 320, 500,    320, 0, 320, 479};
    for (int i = 0; i < 4; i++) begin
      if ((ref_oc(vecs[i].ax0, vecs[i].ay0) & ref_oc(vecs[i].ax1, vecs[i].ay1)) == 0)
        exp_q.push_back('{vecs[i].ex0, vecs[i].ey0, vecs[i].ex1, vecs[i].ey1});
    end

    rst_n = 1'b0;
    force dut.clipper.timing.refresh_cnt = 21'd0;
    repeat (3) @(negedge clkin);
    chk("rst_x0", x0, 0);
    chk("rst_y0", y0, 0);
    chk("rst_x1", x1, 0);
    chk("rst_y1", y1, 0);
    chk("rst_vld", vld, 0);
    chk("rst_busy", busy, 0);
    release dut.clipper.timing.refresh_cnt;
    @(negedge clkin);
    rst_n = 1'b1;

    quiet(1000, bad);
    chk("idle_10us_quiet", bad, 0);
    chk("idle_x0_zero", x0, 0);
    chk("idle_y1_zero", y1, 0);
    chk("refresh_cnt_after_1000", dut.clipper.timing.refresh_cnt, 1000);

    force dut.clipper.timing.refresh_cnt = 21'd1666666;
    repeat (3) @(negedge clkin);
    chk("below_max_no_tick", busy, 0);

    trigger();
    run_frame(-1);
    last = exp_q[exp_q.size() - 1];
    quiet(30, bad);
    chk("after_frame1_quiet", bad, 0);
    chk("hold_x0", x0, last.x0);
    chk("hold_y0", y0, last.y0);
    chk("hold_x1", x1, last.x1);
    chk("hold_y1", y1, last.y1);
    chk("timer_wrapped_small", (dut.clipper.timing.refresh_cnt < 21'd100) ? 1 : 0, 1);

    r = $urandom_range(20, 2);
    trigger();
    run_frame(r);
    quiet(30, bad);
    chk("retrigger_while_busy_ignored", bad, 0);
`ifdef CLIP_STATS_EN
    chk("reject_cnt_two_frames", rej, 2);
`endif

    edge_x = '{0, -1, 639, 640, 100, 100};
    edge_y = '{0, 100, 479, 100, -1, 480};
    for (int i = 0; i < 36; i++) begin
      int     px;
      int     py;
      point_t p;
      if (i < 6) begin
        px = edge_x[i];
        py = edge_y[i];
      end else begin
        px = int'($urandom_range(2000)) - 1000;
        py = int'($urandom_range(2000)) - 1000;
      end
      p.x = 16'(px);
      p.y = 16'(py);
      chk($sformatf("outcode_%0d_%0d", px, py), longint'(outcode(p)), ref_oc(px, py));
    end

    for (int t = 0; t < 2; t++) begin
      k = $urandom_range(50, 5);
      trigger();
      repeat (k) @(negedge clkin);
      rst_n = 1'b0;
      #1;
      chk($sformatf("midrst%0d_x0", t), x0, 0);
      chk($sformatf("midrst%0d_y0", t), y0, 0);
      chk($sformatf("midrst%0d_x1", t), x1, 0);
      chk($sformatf("midrst%0d_y1", t), y1, 0);
      chk($sformatf("midrst%0d_vld", t), vld, 0);
      chk($sformatf("midrst%0d_busy", t), busy, 0);
      @(negedge clkin);
      rst_n = 1'b1;
      quiet(100, bad);
      chk($sformatf("midrst%0d_no_resume", t), bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
